updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 154 +++++++++++++++
 tb/tb_updown_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter
//
// Modulo-MODULUS up/down counter with an optional clock prescaler, parallel load and
// registered tick / terminal-count pulses. Everything is clocked on the rising edge of
// CLOCK_50; Resetn is sampled synchronously.
//
// Configuration macro:
//   UPDOWN_COUNTER_PRESCALE_EN  defined   -> a prescaler divides CLOCK_50 by PRESCALE, and
//                                            one count tick happens every PRESCALE enabled
//                                            cycles.
//                               undefined -> no prescaler is built, PRESCALE is ignored, and
//                                            every enabled cycle is a tick.
//
// Parameters:
//   WIDTH     count register width in bits
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   PRESCALE  CLOCK_50 cycles per count tick (>= 1)
//   WRAP      1 = wrap at the range ends, 0 = saturate
//
// Ports:
//   CLOCK_50  in   clock
//   Resetn    in   synchronous active-low reset; clears Q, prescaler, Tick and TC
//   En        in   count enable; the prescaler holds while low
//   Up        in   direction, sampled only on tick edges (1 = up, 0 = down)
//   Load      in   parallel load of D (clamped to MODULUS-1); beats a coincident tick
//   D         in   load value
//   Q         out  registered count
//   Tick      out  one-cycle pulse following each tick edge
//   TC        out  one-cycle pulse following a tick edge that found Q at the terminal value
//                  for the sampled direction
module updown_counter #(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned MODULUS  = 1024,
   parameter int unsigned PRESCALE = 50000000,
   parameter int unsigned WRAP     = 1
) (
   input  logic             CLOCK_50,
   input  logic             Resetn,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Tick,
   output logic             TC
);

   // Elaboration-time legality checks on the parameter set.
   if (MODULUS < 2) begin : g_bad_modulus_low
      $error("updown_counter: MODULUS must be at least 2");
   end
   if ((WIDTH < 32) && (MODULUS > (32'd1 << WIDTH))) begin : g_bad_modulus_high
      $error("updown_counter: MODULUS must not exceed 2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("updown_counter: PRESCALE must be at least 1");
   end

   localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tick_q, tick_d;
   logic             tc_q, tc_d;
   logic             tick_en;
   logic             at_term;
   logic [WIDTH-1:0] load_val;

   // ---------------------------------------------------------------------------------------
   // Tick generation
   // ---------------------------------------------------------------------------------------
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   localparam int unsigned PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

   logic [PreW-1:0] pre_q, pre_d;

   // The prescaler restarts on load so the first tick after a load is a full interval away.
   always_comb begin
      pre_d   = pre_q;
      tick_en = 1'b0;
      if (Load) begin
         pre_d = '0;
      end else if (En) begin
         if (pre_q == PreLast) begin
            pre_d   = '0;
            tick_en = 1'b1;
         end else begin
            pre_d = pre_q + PreW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick_en = En & ~Load;
`endif

   // ---------------------------------------------------------------------------------------
   // Count register and output pulses
   // ---------------------------------------------------------------------------------------
   // Out-of-range loads clamp to the top of the range.
   always_comb begin
      if (32'(D) >= MODULUS) begin
         load_val = MaxQ;
      end else begin
         load_val = D;
      end
   end

   assign at_term = Up ? (q_q == MaxQ) : (q_q == '0);

   always_comb begin
      q_d    = q_q;
      tick_d = 1'b0;
      tc_d   = 1'b0;
      if (Load) begin
         q_d = load_val;
      end else if (tick_en) begin
         tick_d = 1'b1;
         tc_d   = at_term;
         if (at_term) begin
            // Saturating mode leaves Q where it is.
            if (WRAP != 0) begin
               q_d = Up ? '0 : MaxQ;
            end
         end else begin
            q_d = Up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         q_q    <= '0;
         tick_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         q_q    <= q_d;
         tick_q <= tick_d;
         tc_q   <= tc_d;
      end
   end

   assign Q    = q_q;
   assign Tick = tick_q;
   assign TC   = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter. Two instances (wrapping and saturating) share one
// stimulus stream; a behavioural model of both is compared on every cycle, and a directed
// preamble pins the model with hand-computed values before a randomized phase.
module tb_updown_counter;

   localparam int unsigned W   = 4;
   localparam int unsigned MOD = 10;
   localparam int unsigned PRE = 4;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   localparam int PS = PRE;
`else
   localparam int PS = 1;
`endif

   logic         clk = 1'b0;
   logic         rstn, en, up, load;
   logic [W-1:0] d;
   logic [W-1:0] q_w, q_s;
   logic         tick_w, tick_s, tc_w, tc_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(PRE), .WRAP(1)) u_wrap (
      .CLOCK_50 (clk),
      .Resetn   (rstn),
      .En       (en),
      .Up       (up),
      .Load     (load),
      .D        (d),
      .Q        (q_w),
      .Tick     (tick_w),
      .TC       (tc_w)
   );

   updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(PRE), .WRAP(0)) u_sat (
      .CLOCK_50 (clk),
      .Resetn   (rstn),
      .En       (en),
      .Up       (up),
      .Load     (load),
      .D        (d),
      .Q        (q_s),
      .Tick     (tick_s),
      .TC       (tc_s)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------------------
   // Behavioural model: index 0 = wrapping instance, index 1 = saturating instance.
   // ---------------------------------------------------------------------------------------
   int m_q[2];
   int m_tick[2];
   int m_tc[2];
   int m_p;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      bit fire;
      if (!rstn) begin
         m_p = 0;
         for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_tick[k] = 0; m_tc[k] = 0;
         end
         m_valid = 1'b1;
      end else if (load) begin
         m_p = 0;
         for (int k = 0; k < 2; k++) begin
            m_q[k]    = (int'(d) >= MOD) ? MOD - 1 : int'(d);
            m_tick[k] = 0;
            m_tc[k]   = 0;
         end
      end else if (!en) begin
         for (int k = 0; k < 2; k++) begin
            m_tick[k] = 0; m_tc[k] = 0;
         end
      end else begin
         fire = (m_p == PS - 1);
         m_p  = fire ? 0 : m_p + 1;
         for (int k = 0; k < 2; k++) begin
            m_tick[k] = fire ? 1 : 0;
            m_tc[k]   = (fire && ((up && m_q[k] == MOD - 1) || (!up && m_q[k] == 0))) ? 1 : 0;
         end
         if (fire) begin
            m_q[0] = (m_q[0] + (up ? 1 : MOD - 1)) % MOD;
            if (up) m_q[1] = (m_q[1] + 1 > MOD - 1) ? MOD - 1 : m_q[1] + 1;
            else    m_q[1] = (m_q[1] - 1 < 0) ? 0 : m_q[1] - 1;
         end
      end
   end

   // Compare process, sampling 2 time units after the active edge.
   always @(posedge clk) begin
      #2;
      if (m_valid) begin
         chk("q_wrap",    int'(q_w),    m_q[0]);
         chk("tick_wrap", int'(tick_w), m_tick[0]);
         chk("tc_wrap",   int'(tc_w),   m_tc[0]);
         chk("q_sat",     int'(q_s),    m_q[1]);
         chk("tick_sat",  int'(tick_s), m_tick[1]);
         chk("tc_sat",    int'(tc_s),   m_tc[1]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------------------------------------------------------------------------------
   // Stimulus with hand-computed expectations
   // ---------------------------------------------------------------------------------------
   initial begin
      int ticks, tcs, tcs_s;
      rstn = 1'b0; load = 1'b1; d = 4'd5; en = 1'b1; up = 1'b1;
      step(2);
      chk("lit_reset_q",    int'(q_w),    0);
      chk("lit_reset_tick", int'(tick_w), 0);
      chk("lit_reset_tc",   int'(tc_w),   0);
      chk("lit_reset_q_sat", int'(q_s),   0);

      // Count up through a full range.
      rstn = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
      ticks = 0; tcs = 0; tcs_s = 0;
      repeat (10 * PS) begin
         step(1);
         ticks += int'(tick_w);
         tcs   += int'(tc_w);
         tcs_s += int'(tc_s);
      end
      chk("lit_up_ticks",  ticks, 10);
      chk("lit_up_tc",     tcs, 1);
      chk("lit_up_q_wrap", int'(q_w), 0);
      chk("lit_up_q_sat",  int'(q_s), 9);
      chk("lit_up_tc_sat", tcs_s, 1);

      // Count down from 0.
      up = 1'b0;
      step(PS);
      chk("lit_down_q_wrap",  int'(q_w),  9);
      chk("lit_down_tc_wrap", int'(tc_w), 1);
      chk("lit_down_q_sat",   int'(q_s),  8);
      chk("lit_down_tc_sat",  int'(tc_s), 0);
      step(PS);
      chk("lit_down2_q_wrap",  int'(q_w),  8);
      chk("lit_down2_tc_wrap", int'(tc_w), 0);

      // Load, clamp, and load on a tick edge.
      en = 1'b0; load = 1'b1; d = 4'd7;
      step(1);
      chk("lit_load7_q",    int'(q_w),    7);
      chk("lit_load7_tick", int'(tick_w), 0);
      d = 4'd12;
      step(1);
      chk("lit_clamp_q_wrap", int'(q_w), 9);
      chk("lit_clamp_q_sat",  int'(q_s), 9);
      load = 1'b0; en = 1'b1; up = 1'b1;
      step(PS - 1);
      load = 1'b1; d = 4'd3;
      step(1);
      chk("lit_load_tick_q",    int'(q_w),    3);
      chk("lit_load_tick_tick", int'(tick_w), 0);

      // Saturation at the top, then reverse.
      d = 4'd9;
      step(1);
      load = 1'b0; up = 1'b1;
      step(PS);
      chk("lit_sat_q",       int'(q_s),    9);
      chk("lit_sat_tc",      int'(tc_s),   1);
      chk("lit_sat_tick",    int'(tick_s), 1);
      chk("lit_sat_wrap_q",  int'(q_w),    0);
      step(PS);
      chk("lit_sat2_q",  int'(q_s),  9);
      chk("lit_sat2_tc", int'(tc_s), 1);
      up = 1'b0;
      step(PS);
      chk("lit_sat_down_q",  int'(q_s),  8);
      chk("lit_sat_down_tc", int'(tc_s), 0);

      // Freeze with En low.
      en = 1'b0;
      step(3);
      chk("lit_freeze_q",    int'(q_s),    8);
      chk("lit_freeze_tick", int'(tick_s), 0);

      // Reset in the middle of an interval beats the enable.
      en = 1'b1;
      step(1);
      rstn = 1'b0;
      step(1);
      chk("lit_midreset_q_wrap", int'(q_w),    0);
      chk("lit_midreset_q_sat",  int'(q_s),    0);
      chk("lit_midreset_tick",   int'(tick_w), 0);
      rstn = 1'b1;

      // Randomized phase, checked by the per-cycle compare process.
      repeat (3000) begin
         rstn = ($urandom_range(0, 199) != 0);
         load = ($urandom_range(0, 24) == 0);
         en   = ($urandom_range(0, 3) != 0);
         up   = ($urandom_range(0, 1) == 1);
         d    = W'($urandom_range(0, 15));
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
